// File: rtl/instr_fetch.sv
// Instruction sequencer: owns the PC, fetches 16-bit words over a req/valid
// handshake, presents op/operand to the decoder and picks the next PC from
// the decoder's jump/branch outputs once the datapath finishes the instruction.
module instr_fetch #(
  parameter int ADDR_W                = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int CNT_W                 = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [3:0]        op,
  output logic [11:0]       operand,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              jump,
  input  logic              branch,
  input  logic              acc_zero,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [15:0]         instr_q, instr_d;
  logic [CNT_W-1:0]    retired_q, retired_d;

  logic [ADDR_W-1:0]   target;
  logic [ADDR_W-1:0]   pc_inc;
  logic                take_target;

  // Control-flow target comes straight from the operand; jump takes priority
  // over branch, and a branch with a non-zero accumulator falls through.
  always_comb begin
    target      = instr_q[ADDR_W-1:0];
    pc_inc      = pc_q + ADDR_W'(1);
    take_target = jump | (branch & acc_zero);
  end

  // Next-state logic for the sequencer and all architectural registers.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        // run is deliberately not sampled here: an issued fetch always completes.
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (exec_done) begin
          pc_d = take_target ? target : pc_inc;
          if (retired_q != {CNT_W{1'b1}}) retired_d = retired_q + CNT_W'(1);
          state_d = run ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; async reset aborts any fetch or issue in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // Outputs are decoded from the registered state only.
  always_comb begin
    imem_req    = (state_q == FETCH);
    imem_addr   = pc_q;
    instr_valid = (state_q == ISSUE);
    busy        = (state_q != IDLE);
    op          = instr_q[15:12];
    operand     = instr_q[11:0];
    pc          = pc_q;
    retired     = retired_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch. Memory is modelled as a combinational
// array; the decoder's jump/branch/acc_zero are driven directly per scenario.
// The retired counter is shrunk to 4 bits so saturation is reachable quickly.
module tb_instr_fetch;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              run;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_rdata;
  logic              imem_valid;
  logic [3:0]        op;
  logic [11:0]       operand;
  logic              instr_valid;
  logic              exec_done;
  logic              jump;
  logic              branch;
  logic              acc_zero;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic [CNT_W-1:0]  retired;

  logic [15:0] mem [0:4095];
  logic        auto_valid;
  logic        man_valid;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(12'h000), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .op(op), .operand(operand),
    .instr_valid(instr_valid), .exec_done(exec_done), .jump(jump),
    .branch(branch), .acc_zero(acc_zero), .pc(pc), .busy(busy),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];
  assign imem_valid = auto_valid ? imem_req : man_valid;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; run = 1'b0; exec_done = 1'b0;
    jump = 1'b0; branch = 1'b0; acc_zero = 1'b0;
    auto_valid = 1'b1; man_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    clear_mem();
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_ivalid: got %b expected 0", instr_valid); end
    checks++; if (pc !== 12'h000) begin errors++; $display("FAIL reset_pc: got %h expected 000", pc); end
    checks++; if (retired !== 4'h0) begin errors++; $display("FAIL reset_retired: got %h expected 0", retired); end
    checks++; if (op !== 4'h0) begin errors++; $display("FAIL reset_op: got %h expected 0", op); end
    $display("test_reset: done");
  endtask

  // LOADI 5 at address 0, zero-wait memory, exec_done immediate.
  task automatic test_basic;
    clear_mem();
    mem[0] = 16'h4005;
    do_reset();
    run = 1'b1; exec_done = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin errors++; $display("FAIL basic_fetch: got req=%b addr=%h expected req=1 addr=000", imem_req, imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_fetch_ivalid: got %b expected 0", instr_valid); end
    tick();
    checks++; if (op !== 4'h4 || operand !== 12'h005 || instr_valid !== 1'b1) begin errors++; $display("FAIL basic_issue: got op=%h operand=%h iv=%b expected op=4 operand=005 iv=1", op, operand, instr_valid); end
    tick();
    checks++; if (pc !== 12'h001 || retired !== 4'h1) begin errors++; $display("FAIL basic_retire: got pc=%h retired=%h expected pc=001 retired=1", pc, retired); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h001) begin errors++; $display("FAIL basic_next_fetch: got req=%b addr=%h expected req=1 addr=001", imem_req, imem_addr); end
    // run drops while fetching: the NOP at 1 is still fetched, issued and retired
    run = 1'b0;
    tick();
    checks++; if (instr_valid !== 1'b1 || op !== 4'h0) begin errors++; $display("FAIL basic_nop_issue: got iv=%b op=%h expected iv=1 op=0", instr_valid, op); end
    tick();
    checks++; if (busy !== 1'b0 || pc !== 12'h002 || retired !== 4'h2) begin errors++; $display("FAIL basic_stop: got busy=%b pc=%h retired=%h expected busy=0 pc=002 retired=2", busy, pc, retired); end
    exec_done = 1'b0;
    $display("test_basic: done");
  endtask

  // JUMP 3, then JUMP 0x020 from pc=3.
  task automatic test_jump;
    clear_mem();
    mem[0] = 16'h1003;
    mem[3] = 16'h1020;
    do_reset();
    run = 1'b1; exec_done = 1'b1; jump = 1'b1;
    tick(); tick(); tick();
    checks++; if (imem_addr !== 12'h003) begin errors++; $display("FAIL jump_to_3: got addr=%h expected 003", imem_addr); end
    tick();
    checks++; if (op !== 4'h1 || operand !== 12'h020) begin errors++; $display("FAIL jump_issue: got op=%h operand=%h expected op=1 operand=020", op, operand); end
    tick();
    checks++; if (imem_addr !== 12'h020 || retired !== 4'h2) begin errors++; $display("FAIL jump_target: got addr=%h retired=%h expected addr=020 retired=2", imem_addr, retired); end
    $display("test_jump: done");
  endtask

  // BZ 0x010 at pc=7, taken and not taken.
  task automatic test_branch;
    clear_mem();
    mem[0]     = 16'h1007;
    mem[7]     = 16'hF010;
    mem[12'h10] = 16'h1007;
    do_reset();
    run = 1'b1; exec_done = 1'b1; jump = 1'b1;
    tick(); tick(); tick();
    jump = 1'b0; branch = 1'b1; acc_zero = 1'b1;
    tick();
    checks++; if (op !== 4'hF || pc !== 12'h007) begin errors++; $display("FAIL bz_issue: got op=%h pc=%h expected op=f pc=007", op, pc); end
    tick();
    checks++; if (pc !== 12'h010) begin errors++; $display("FAIL bz_taken: got pc=%h expected 010", pc); end
    jump = 1'b1; branch = 1'b0;
    tick(); tick();
    jump = 1'b0; branch = 1'b1; acc_zero = 1'b0;
    tick(); tick();
    checks++; if (pc !== 12'h008) begin errors++; $display("FAIL bz_not_taken: got pc=%h expected 008", pc); end
    $display("test_branch: done");
  endtask

  // Fetch with three wait states, then exec_done held off for five cycles.
  task automatic test_wait;
    clear_mem();
    mem[0] = 16'h2ABC;
    do_reset();
    auto_valid = 1'b0; man_valid = 1'b0;
    run = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h000 || instr_valid !== 1'b0) begin errors++; $display("FAIL wait_fetch_%0d: got req=%b addr=%h iv=%b expected req=1 addr=000 iv=0", i, imem_req, imem_addr, instr_valid); end
      if (i == 3) man_valid = 1'b1;
      tick();
    end
    man_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (instr_valid !== 1'b1 || op !== 4'h2 || operand !== 12'hABC || pc !== 12'h000) begin errors++; $display("FAIL wait_hold_%0d: got iv=%b op=%h operand=%h pc=%h expected iv=1 op=2 operand=abc pc=000", i, instr_valid, op, operand, pc); end
      tick();
    end
    exec_done = 1'b1;
    tick();
    checks++; if (pc !== 12'h001 || retired !== 4'h1) begin errors++; $display("FAIL wait_retire: got pc=%h retired=%h expected pc=001 retired=1", pc, retired); end
    exec_done = 1'b0;
    $display("test_wait: done");
  endtask

  // PC wrap at 0xFFF, jump priority over branch, retired-counter saturation.
  task automatic test_boundary;
    clear_mem();
    mem[0]      = 16'h1FFF;
    mem[12'hFFF] = 16'h3123;
    do_reset();
    run = 1'b1; exec_done = 1'b1; jump = 1'b1;
    tick(); tick(); tick();
    checks++; if (pc !== 12'hFFF) begin errors++; $display("FAIL bnd_reach_fff: got pc=%h expected fff", pc); end
    jump = 1'b0;
    tick(); tick();
    checks++; if (pc !== 12'h000) begin errors++; $display("FAIL bnd_wrap: got pc=%h expected 000", pc); end
    // jump and branch both set with acc_zero=0: jump target, not fall-through
    jump = 1'b1; branch = 1'b1; acc_zero = 1'b0;
    tick(); tick();
    checks++; if (pc !== 12'hFFF || retired !== 4'h3) begin errors++; $display("FAIL bnd_jump_prio: got pc=%h retired=%h expected pc=fff retired=3", pc, retired); end
    jump = 1'b0; branch = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(); tick(); end
    checks++; if (retired !== 4'hF) begin errors++; $display("FAIL bnd_reach_max: got %h expected f", retired); end
    tick(); tick(); tick(); tick();
    checks++; if (retired !== 4'hF) begin errors++; $display("FAIL bnd_saturate: got %h expected f", retired); end
    exec_done = 1'b0;
    $display("test_boundary: done");
  endtask

  // Stop at instruction boundary, then async reset in the middle of a fetch.
  task automatic test_stop_reset;
    clear_mem();
    mem[0] = 16'h5001;
    do_reset();
    run = 1'b1;
    tick(); tick();
    run = 1'b0; exec_done = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || pc !== 12'h001 || imem_req !== 1'b0 || retired !== 4'h1) begin errors++; $display("FAIL stop_idle: got busy=%b pc=%h req=%b retired=%h expected busy=0 pc=001 req=0 retired=1", busy, pc, imem_req, retired); end
    exec_done = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_stays_idle: got busy=%b expected 0", busy); end
    auto_valid = 1'b0; man_valid = 1'b0; run = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h001) begin errors++; $display("FAIL rst_pre_fetch: got req=%b addr=%h expected req=1 addr=001", imem_req, imem_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || pc !== 12'h000 || imem_req !== 1'b0) begin errors++; $display("FAIL rst_async: got busy=%b pc=%h req=%b expected busy=0 pc=000 req=0", busy, pc, imem_req); end
    man_valid = 1'b1; run = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || instr_valid !== 1'b0 || op !== 4'h0 || operand !== 12'h000) begin errors++; $display("FAIL rst_late_valid: got busy=%b iv=%b op=%h operand=%h expected busy=0 iv=0 op=0 operand=000", busy, instr_valid, op, operand); end
    man_valid = 1'b0;
    $display("test_stop_reset: done");
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; exec_done = 1'b0;
    jump = 1'b0; branch = 1'b0; acc_zero = 1'b0;
    auto_valid = 1'b1; man_valid = 1'b0;
    test_reset();
    test_basic();
    test_jump();
    test_branch();
    test_wait();
    test_boundary();
    test_stop_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
